i2c_phase_timer: RTL and testbench

I2C_PHASE_TIMER -- requirements
Module: i2c_phase_timer

---
 rtl/i2c_phase_timer_pkg.sv | 10 +
 rtl/i2c_tick_counter.sv | 28 ++
 rtl/i2c_phase_timer.sv | 104 ++++++++++
 tb/tb_i2c_phase_timer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/i2c_phase_timer_pkg.sv
// Shared I2C timing definitions: controller state encoding and phase defaults,
// imported by the phase timer and by the I2C master FSM.
package i2c_phase_timer_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  localparam int unsigned DefPhases       = 4;
  localparam int unsigned DefStretchPhase = 2;

endpackage

// File: rtl/i2c_tick_counter.sv
// Reloadable down-counter that sets the length of one I2C bit phase.
// Load has priority over En; Zero flags the last cycle of the phase.
module i2c_tick_counter #(
  parameter int unsigned SIZE = 8
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Load,
  input  logic            En,
  input  logic [SIZE-1:0] Ticks,
  output logic            Zero
);

  logic [SIZE-1:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else if (Load) begin
      cnt_q <= Ticks;
    end else if (En) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign Zero = (cnt_q == '0);

endmodule

// File: rtl/i2c_phase_timer.sv
// I2C bit phase sequencer: steps through PHASES phases of Ticks+1 cycles each,
// with SCL-stretch hold in one phase, freeze on Stop and single-bit mode.
module i2c_phase_timer
  import i2c_phase_timer_pkg::*;
#(
  parameter int unsigned SIZE          = 8,
  parameter int unsigned PHASES        = DefPhases,
  parameter int unsigned PW            = 2,
  parameter int unsigned STRETCH_PHASE = DefStretchPhase
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Start,
  input  logic            Stop,
  input  logic            Hold,
  input  logic            Single,
  input  logic [SIZE-1:0] Ticks,
  output logic            Tick,
  output logic [PW-1:0]   Phase,
  output logic            Bit_done,
  output logic            Busy
);

  localparam logic [PW-1:0] LastPhase    = PW'(PHASES - 1);
  localparam logic [PW-1:0] StretchPhase = PW'(STRETCH_PHASE);

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          tick_q, tick_d;
  logic          bit_done_q, bit_done_d;
  logic          cnt_load, cnt_en, cnt_zero;

  i2c_tick_counter #(
    .SIZE (SIZE)
  ) u_tick_counter (
    .Clk   (Clk),
    .Rst   (Rst),
    .Load  (cnt_load),
    .En    (cnt_en),
    .Ticks (Ticks),
    .Zero  (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    tick_d     = 1'b0;
    bit_done_d = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    if (Start) begin
      state_d  = StRun;
      phase_d  = '0;
      tick_d   = 1'b1;
      cnt_load = 1'b1;
    end else if (Stop) begin
      // Everything frozen; strobes already defaulted low.
    end else if (state_q != StIdle) begin
      if (Hold && (phase_q == StretchPhase)) begin
        state_d = StHold;
      end else begin
        // Leaving HOLD counts on the same edge, so held cycles add one-for-one.
        state_d = StRun;
        if (cnt_zero) begin
          cnt_load = 1'b1;
          if (phase_q == LastPhase) begin
            bit_done_d = 1'b1;
            phase_d    = '0;
            if (Single) begin
              state_d = StIdle;
            end else begin
              tick_d = 1'b1;
            end
          end else begin
            phase_d = phase_q + 1'b1;
            tick_d  = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      tick_q     <= 1'b0;
      bit_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      tick_q     <= tick_d;
      bit_done_q <= bit_done_d;
    end
  end

  assign Tick     = tick_q;
  assign Phase    = phase_q;
  assign Bit_done = bit_done_q;
  assign Busy     = (state_q != StIdle);

endmodule

// File: tb/tb_i2c_phase_timer.sv
// Directed bench for i2c_phase_timer: default 4-phase instance plus a
// 2-phase instance for the one-cycle-phase case.
module tb_i2c_phase_timer;

  logic       Clk = 1'b0;
  logic       Rst, Start, Stop, Hold, Single;
  logic [7:0] Ticks;
  logic       Tick, Bit_done, Busy;
  logic [1:0] Phase;

  logic       Start2;
  logic [7:0] Ticks2;
  logic       Tick2, Bit_done2, Busy2;
  logic [0:0] Phase2;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  i2c_phase_timer u_dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .Stop     (Stop),
    .Hold     (Hold),
    .Single   (Single),
    .Ticks    (Ticks),
    .Tick     (Tick),
    .Phase    (Phase),
    .Bit_done (Bit_done),
    .Busy     (Busy)
  );

  i2c_phase_timer #(
    .SIZE          (8),
    .PHASES        (2),
    .PW            (1),
    .STRETCH_PHASE (1)
  ) u_dut2 (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start2),
    .Stop     (1'b0),
    .Hold     (1'b0),
    .Single   (1'b0),
    .Ticks    (Ticks2),
    .Tick     (Tick2),
    .Phase    (Phase2),
    .Bit_done (Bit_done2),
    .Busy     (Busy2)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int k, input int e_tick, input int e_phase,
                         input int e_bd, input int e_busy);
    chk($sformatf("%s k=%0d Tick", tag, k), int'(Tick), e_tick);
    chk($sformatf("%s k=%0d Phase", tag, k), int'(Phase), e_phase);
    chk($sformatf("%s k=%0d Bit_done", tag, k), int'(Bit_done), e_bd);
    chk($sformatf("%s k=%0d Busy", tag, k), int'(Busy), e_busy);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    step();
    step();
    Rst = 1'b0;
  endtask

  initial begin
    Rst = 1'b0; Start = 1'b0; Stop = 1'b0; Hold = 1'b0; Single = 1'b0; Ticks = 8'd3;
    Start2 = 1'b0; Ticks2 = 8'd0;

    // Reset state, and Start coincident with Rst is ignored.
    do_reset();
    chk_out("reset", 0, 0, 0, 0, 0);
    Rst = 1'b1; Start = 1'b1;
    step();
    Rst = 1'b0; Start = 1'b0;
    chk_out("rst_start", 0, 0, 0, 0, 0);
    step();
    chk_out("rst_start_after", 1, 0, 0, 0, 0);

    // Free-running bit, Ticks=3: Tick every 4 cycles, wrap with Bit_done.
    Ticks = 8'd3; Single = 1'b0; Start = 1'b1;
    step();
    Start = 1'b0;
    chk_out("run", 0, 1, 0, 0, 1);
    for (int k = 1; k <= 17; k++) begin
      step();
      chk_out("run", k, (k % 4 == 0) ? 1 : 0, (k / 4) % 4, (k == 16) ? 1 : 0, 1);
    end
    do_reset();

    // Single bit: 4 Ticks, Bit_done at cycle 16, then idle with no strobes.
    Single = 1'b1; Start = 1'b1;
    step();
    Start = 1'b0;
    chk_out("single", 0, 1, 0, 0, 1);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk_out("single", k, (k % 4 == 0 && k < 16) ? 1 : 0, (k < 16) ? k / 4 : 0,
              (k == 16) ? 1 : 0, (k < 16) ? 1 : 0);
    end

    // Ticks=2: Hold in phase 1 ignored, Hold for 5 cycles in phase 2 stretches it to 8.
    Ticks = 8'd2; Start = 1'b1;
    step();
    Start = 1'b0;
    chk_out("hold", 0, 1, 0, 0, 1);
    for (int k = 1; k <= 18; k++) begin
      Hold = ((k == 4) || (k == 5) || (k >= 7 && k <= 11)) ? 1'b1 : 1'b0;
      step();
      chk_out("hold", k, (k == 3 || k == 6 || k == 14) ? 1 : 0,
              (k < 3) ? 0 : (k < 6) ? 1 : (k < 14) ? 2 : (k < 17) ? 3 : 0,
              (k == 17) ? 1 : 0, (k < 17) ? 1 : 0);
    end
    Hold = 1'b0;

    // Ticks=3: Stop for 4 cycles mid-phase 1 lengthens it to 8 cycles.
    Ticks = 8'd3; Start = 1'b1;
    step();
    Start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      Stop = (k >= 5 && k <= 8) ? 1'b1 : 1'b0;
      step();
      chk_out("stop", k, (k == 4 || k == 12) ? 1 : 0, (k < 4) ? 0 : (k < 12) ? 1 : 2, 0, 1);
    end
    Stop = 1'b0;
    do_reset();

    // Ticks=1 free-run: Start on the would-be wrap edge of phase 3 restarts without Bit_done.
    Ticks = 8'd1; Single = 1'b0; Start = 1'b1;
    step();
    Start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      Start = (k == 8) ? 1'b1 : 1'b0;
      step();
      chk_out("restart", k, (k % 2 == 0) ? 1 : 0, (k == 8) ? 0 : (k / 2) % 4, 0, 1);
    end
    Start = 1'b0;
    // Enter HOLD in phase 2, then reset while held.
    for (int k = 1; k <= 5; k++) begin
      Hold = (k == 5) ? 1'b1 : 1'b0;
      step();
      chk_out("rst_hold", k, (k == 2 || k == 4) ? 1 : 0, k / 2, 0, 1);
    end
    Rst = 1'b1;
    step();
    chk_out("rst_hold_rst", 6, 0, 0, 0, 0);
    Rst = 1'b0; Hold = 1'b0;
    step();
    chk_out("rst_hold_idle", 7, 0, 0, 0, 0);

    // PHASES=2, Ticks=0: Tick every cycle, Phase toggles, Bit_done every 2nd cycle.
    Ticks2 = 8'd0; Start2 = 1'b1;
    step();
    Start2 = 1'b0;
    chk("p2 k=0 Tick", int'(Tick2), 1);
    chk("p2 k=0 Phase", int'(Phase2), 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("p2 k=%0d Tick", k), int'(Tick2), 1);
      chk($sformatf("p2 k=%0d Phase", k), int'(Phase2), k % 2);
      chk($sformatf("p2 k=%0d Bit_done", k), int'(Bit_done2), (k % 2 == 0) ? 1 : 0);
      chk($sformatf("p2 k=%0d Busy", k), int'(Busy2), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
